// File: rtl/capture_log_reader_pkg.sv
// Shared defaults and FSM state encoding for the capture log reader.
package capture_log_reader_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/capture_log_reader_log_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no array reset.
module log_ram #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic               rd_en,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [NB_DATA-1:0] rd_data
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/capture_log_reader.sv
// Capture buffer: arm starts a DEPTH-word capture into RAM, then the host
// reads words back one at a time through level-to-edge VIO handshakes.
module capture_log_reader
    import capture_log_reader_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_arm,
    input  logic               i_rd_req,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_rd_ack,
    output logic               o_full,
    output logic [1:0]         o_state,
    output logic [NB_ADDR:0]   o_count
);

    localparam logic [NB_ADDR:0] LAST_IDX = (NB_ADDR+1)'((2**NB_ADDR) - 1);

    state_t             state_q, state_d;
    logic               arm_q, rd_q;
    logic               arm_edge, rd_edge;
    logic [NB_ADDR:0]   count_q;
    logic               wr_en, last_wr, rd_fire, rd_pend_q;
    logic [NB_DATA-1:0] ram_rd_data;

    assign arm_edge = i_arm & ~arm_q;
    assign rd_edge  = i_rd_req & ~rd_q;
    assign wr_en    = (state_q == ST_CAPTURE) && i_valid;
    assign last_wr  = wr_en && (count_q == LAST_IDX);
    // An arm edge in the same DONE cycle wins over the read edge.
    assign rd_fire  = (state_q == ST_DONE) && rd_edge && !arm_edge;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            arm_q   <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            arm_q   <= i_arm;
            rd_q    <= i_rd_req;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm_edge) state_d = ST_CAPTURE;
            ST_CAPTURE: if (last_wr)  state_d = ST_DONE;
            ST_DONE:    if (arm_edge) state_d = ST_CAPTURE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (arm_edge && (state_q != ST_CAPTURE)) begin
            count_q <= '0;
        end else if (wr_en) begin
            count_q <= count_q + 1'b1;
        end
    end

    log_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_log_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_q[NB_ADDR-1:0]),
        .wr_data (i_data),
        .rd_en   (rd_fire),
        .rd_addr (i_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Read handshake: a rising i_rd_req in DONE launches one read; o_rd_ack
    // rises two cycles later with o_rd_data valid and stays high while
    // i_rd_req is held, falling the cycle after i_rd_req is seen low.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rd_pend_q <= 1'b0;
            o_rd_data <= '0;
            o_rd_ack  <= 1'b0;
        end else begin
            rd_pend_q <= rd_fire;
            if (arm_edge) begin
                o_rd_ack <= 1'b0;
            end else if (rd_pend_q && (state_q == ST_DONE)) begin
                o_rd_data <= ram_rd_data;
                o_rd_ack  <= i_rd_req;
            end else if (!i_rd_req) begin
                o_rd_ack <= 1'b0;
            end
        end
    end

    assign o_full  = (state_q == ST_DONE);
    assign o_state = state_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_capture_log_reader.sv
// Directed bench for capture_log_reader: scoreboard queue checked by a read monitor.
module tb_capture_log_reader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_data;
    logic        i_valid;
    logic        i_arm;
    logic        i_rd_req;
    logic [9:0]  i_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_ack;
    logic        o_full;
    logic [1:0]  o_state;
    logic [10:0] o_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        ack_prev = 1'b0;

    always #5 clk = ~clk;

    capture_log_reader dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_arm     (i_arm),
        .i_rd_req  (i_rd_req),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .o_rd_ack  (o_rd_ack),
        .o_full    (o_full),
        .o_state   (o_state),
        .o_count   (o_count)
    );

    // Monitor: each rising ack presents one word to the scoreboard.
    always @(negedge clk) begin
        if (o_rd_ack && !ack_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data_unexpected: got %h with no read outstanding", o_rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (o_rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", o_rd_data, e);
                end
            end
        end
        ack_prev = o_rd_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_rd_data"}, o_rd_data, 32'h0);
        check({name, "_rd_ack"},  {31'h0, o_rd_ack}, 32'h0);
        check({name, "_full"},    {31'h0, o_full},   32'h0);
        check({name, "_state"},   {30'h0, o_state},  32'h0);
        check({name, "_count"},   {21'h0, o_count},  32'h0);
    endtask

    task automatic arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input int from, input int to);
        for (int k = from; k < to; k++) begin
            i_valid = 1'b1;
            i_data  = base + 32'(k);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [31:0] exp);
        i_rd_addr = addr;
        i_rd_req  = 1'b1;
        exp_q.push_back(exp);
        tick();
        check("ack_at_edge1", {31'h0, o_rd_ack}, 32'h0);
        tick();
        check("ack_at_edge2", {31'h0, o_rd_ack}, 32'h1);
        i_rd_req = 1'b0;
        tick();
        check("ack_drop", {31'h0, o_rd_ack}, 32'h0);
    endtask

    initial begin
        i_reset = 1'b1; i_data = '0; i_valid = 1'b0; i_arm = 1'b0;
        i_rd_req = 1'b0; i_rd_addr = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        i_reset = 1'b0;
        tick();

        // Read in IDLE must not ack.
        i_rd_addr = 10'd3;
        i_rd_req  = 1'b1;
        repeat (4) tick();
        check("idle_read_ack", {31'h0, o_rd_ack}, 32'h0);
        check("idle_state", {30'h0, o_state}, 32'h0);
        i_rd_req = 1'b0;
        tick();

        // Full capture with data = index.
        arm();
        check("arm_state", {30'h0, o_state}, 32'h1);
        check("arm_count", {21'h0, o_count}, 32'h0);
        fill(32'h0, 0, 1023);
        check("cap_count_1023", {21'h0, o_count}, 32'd1023);
        check("cap_state_1023", {30'h0, o_state}, 32'h1);
        check("cap_full_1023", {31'h0, o_full}, 32'h0);
        fill(32'h0, 1023, 1024);
        check("cap_count_full", {21'h0, o_count}, 32'd1024);
        check("cap_state_done", {30'h0, o_state}, 32'h2);
        check("cap_full", {31'h0, o_full}, 32'h1);
        repeat (3) tick();
        check("done_count_hold", {21'h0, o_count}, 32'd1024);

        do_read(10'd0, 32'd0);
        do_read(10'd5, 32'd5);
        do_read(10'd1023, 32'd1023);

        // Re-arm while a read request is held high.
        i_rd_addr = 10'd7;
        i_rd_req  = 1'b1;
        exp_q.push_back(32'd7);
        repeat (2) tick();
        check("held_ack", {31'h0, o_rd_ack}, 32'h1);
        arm();
        check("rearm_ack", {31'h0, o_rd_ack}, 32'h0);
        check("rearm_full", {31'h0, o_full}, 32'h0);
        check("rearm_state", {30'h0, o_state}, 32'h1);
        check("rearm_count", {21'h0, o_count}, 32'h0);
        i_rd_req = 1'b0;

        // Gapped valid: every third cycle.
        for (int j = 0; j < 9; j++) begin
            i_valid = (j % 3 == 0);
            i_data  = 32'hA000 + 32'(j);
            tick();
            check("gap_count", {21'h0, o_count}, 32'(j / 3 + 1));
        end
        i_valid = 1'b0;
        fill(32'hB000, 3, 1024);
        check("gap_state_done", {30'h0, o_state}, 32'h2);
        do_read(10'd0, 32'hA000);
        do_read(10'd1, 32'hA003);
        do_read(10'd2, 32'hA006);
        do_read(10'd3, 32'hB003);

        // Reset mid-capture at count 300, asserted between clock edges.
        arm();
        fill(32'hC000, 0, 300);
        check("pre_reset_count", {21'h0, o_count}, 32'd300);
        @(posedge clk);
        #3 i_reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        tick();
        i_reset = 1'b0;
        tick();
        arm();
        check("post_reset_count", {21'h0, o_count}, 32'h0);
        fill(32'hD000, 0, 1024);
        check("post_reset_final", {21'h0, o_count}, 32'd1024);
        check("post_reset_full", {31'h0, o_full}, 32'h1);
        do_read(10'd0, 32'hD000);
        do_read(10'd299, 32'hD12B);
        do_read(10'd1023, 32'hD3FF);

        repeat (4) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
